// File: rtl/seq_compare_pkg.sv
// seq_compare shared definitions: FSM state codes, result codes
// and the cascade resolution helper.
package seq_compare_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    // Only the two one-hot ordering codes pass through; anything else means equal.
    function automatic logic [2:0] resolve_cascade(input logic [2:0] c);
        logic [2:0] r;
        case (c)
            RES_GT:  r = RES_GT;
            RES_LT:  r = RES_LT;
            default: r = RES_EQ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_compare_digit.sv
// compare_digit: combinational DIGIT-bit unsigned magnitude compare.
// Exactly one of gt/lt/eq is high.
module compare_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] iA,
    input  logic [DIGIT-1:0] iB,
    output logic             oGt,
    output logic             oLt,
    output logic             oEq
);

    assign oGt = (iA > iB);
    assign oLt = (iA < iB);
    assign oEq = (iA == iB);

endmodule

// File: rtl/seq_compare.sv
// seq_compare: multi-cycle MSB-first magnitude comparator, one digit per cycle.
// Optional SEQ_CMP_SIGNED_EN adds iSigned for two's-complement ordering.
module seq_compare
    import seq_compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             iSigned,
`endif
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_casc;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_data;

    logic             w_flip;
    logic [WIDTH-1:0] w_cap_a;
    logic [WIDTH-1:0] w_cap_b;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;

`ifdef SEQ_CMP_SIGNED_EN
    assign w_flip = iSigned;
`else
    assign w_flip = 1'b0;
`endif

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign w_cap_a = w_flip ? (iData_a ^ MSB_MASK) : iData_a;
    assign w_cap_b = w_flip ? (iData_b ^ MSB_MASK) : iData_b;

    assign w_da = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_db = r_b[int'(r_cnt) * DIGIT +: DIGIT];

    compare_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .iA  (w_da),
        .iB  (w_db),
        .oGt (w_gt),
        .oLt (w_lt),
        .oEq (w_eq)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_casc  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_a     <= w_cap_a;
                        r_b     <= w_cap_b;
                        r_casc  <= iData;
                        r_cnt   <= CW'(N - 1);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    unique case (1'b1)
                        w_gt: begin
                            r_data  <= RES_GT;
                            r_state <= S_DONE;
                        end
                        w_lt: begin
                            r_data  <= RES_LT;
                            r_state <= S_DONE;
                        end
                        w_eq: begin
                            if (r_cnt == '0) begin
                                r_data  <= resolve_cascade(r_casc);
                                r_state <= S_DONE;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oBusy = (r_state == S_RUN);
    assign oDone = (r_state == S_DONE);
    assign oData = r_data;

endmodule

// File: tb/tb_seq_compare.sv
// Directed self-checking bench for seq_compare (WIDTH=16, DIGIT=4).
// Honours SEQ_CMP_SIGNED_EN when the build defines it.
module tb_seq_compare;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic [2:0]  casc  = '0;
    logic        sgn   = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  data;

    int          n_chk    = 0;
    int          n_fail   = 0;
    logic [2:0]  prev_exp = 3'b000;

    always #5 clk = ~clk;

    seq_compare #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iStart  (start),
        .iData_a (a),
        .iData_b (b),
        .iData   (casc),
`ifdef SEQ_CMP_SIGNED_EN
        .iSigned (sgn),
`endif
        .oBusy   (busy),
        .oDone   (done),
        .oData   (data)
    );

    task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_,
                           input logic [2:0] tc, input logic ts,
                           input logic [2:0] exp, input int k,
                           input string nm);
        int cyc;
        bit seen;
        bit busy_bad;
        @(negedge clk);
        a = ta; b = tb_; casc = tc; sgn = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb_; casc = ~tc; sgn = ~ts;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_accept got=%b want=1", nm, busy);
        end
        n_chk++;
        if (data !== prev_exp) begin
            n_fail++;
            $display("FAIL %s held_result got=%b want=%b", nm, data, prev_exp);
        end
        cyc = 0; seen = 0; busy_bad = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_bad = 1;
        end
        n_chk++;
        if (!seen || cyc != k || busy_bad) begin
            n_fail++;
            $display("FAIL %s latency got=%0d seen=%0d busy_bad=%0d want=%0d",
                     nm, cyc, seen, busy_bad, k);
        end
        n_chk++;
        if (data !== exp) begin
            n_fail++;
            $display("FAIL %s result got=%b want=%b", nm, data, exp);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || data !== exp) begin
            n_fail++;
            $display("FAIL %s after_done done=%b busy=%b data=%b want 0 0 %b",
                     nm, done, busy, data, exp);
        end
        prev_exp = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== 3'b000) begin
            n_fail++;
            $display("FAIL reset busy=%b done=%b data=%b want 0 0 000",
                     busy, done, data);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_cmp(16'h9000, 16'h1000, 3'b001, 1'b0, 3'b100, 1, "top_gt");
        run_cmp(16'h1234, 16'h1235, 3'b001, 1'b0, 3'b010, 4, "low_lt");
        run_cmp(16'h12F4, 16'h1234, 3'b010, 1'b0, 3'b100, 3, "mid_gt");
    endtask

    task automatic test_cascade();
        run_cmp(16'hABCD, 16'hABCD, 3'b100, 1'b0, 3'b100, 4, "casc_gt");
        run_cmp(16'hABCD, 16'hABCD, 3'b010, 1'b0, 3'b010, 4, "casc_lt");
        run_cmp(16'hABCD, 16'hABCD, 3'b011, 1'b0, 3'b001, 4, "casc_bad");
        run_cmp(16'hABCD, 16'hABCD, 3'b001, 1'b0, 3'b001, 4, "casc_eq");
    endtask

    task automatic test_ignore_start();
        int dcnt;
        int dcyc;
        logic [2:0] ddat;
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; casc = 3'b100; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0; dcyc = 0; ddat = 3'b000;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2 || c == 5) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000;
            end else begin
                start = 1'b0; a = 16'h0F0F; b = 16'hF0F0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dcnt++; dcyc = c; ddat = data;
            end
        end
        start = 1'b0;
        n_chk++;
        if (dcnt != 1 || dcyc != 4) begin
            n_fail++;
            $display("FAIL ignore_done count=%0d at=%0d want 1 at 4", dcnt, dcyc);
        end
        n_chk++;
        if (ddat !== 3'b010 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result data=%b busy=%b want 010 0", ddat, busy);
        end
        prev_exp = 3'b010;
    endtask

    task automatic test_reset_mid_run();
        bit done_seen;
        @(negedge clk);
        a = 16'h1111; b = 16'h1112; casc = 3'b001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset busy=%b done=%b data=%b want 0 0 000",
                     busy, done, data);
        end
        done_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) done_seen = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) done_seen = 1;
        end
        n_chk++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL mid_reset_no_done got=1 want=0");
        end
        prev_exp = 3'b000;
        run_cmp(16'h1234, 16'h1234, 3'b001, 1'b0, 3'b001, 4, "post_reset");
    endtask

    task automatic test_signed();
        logic [2:0] exp_s;
        int k_s;
`ifdef SEQ_CMP_SIGNED_EN
        exp_s = 3'b010;
`else
        exp_s = 3'b100;
`endif
        k_s = 1;
        run_cmp(16'h8000, 16'h0001, 3'b001, 1'b1, exp_s, k_s, "signed_sel");
        run_cmp(16'h8000, 16'h0001, 3'b001, 1'b0, 3'b100, 1, "unsigned_sel");
    endtask

    task automatic test_back_to_back();
        run_cmp(16'h0000, 16'h0001, 3'b100, 1'b0, 3'b010, 4, "b2b_first");
        run_cmp(16'hFFFF, 16'hFFFE, 3'b010, 1'b0, 3'b100, 4, "b2b_second");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_cascade();
        test_ignore_start();
        test_reset_mid_run();
        test_signed();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_compare.md
Name: seq_compare

Overview:
- Multi-cycle, parametrised magnitude comparator; successor to the 4-bit cascadable combinational comparator.
- Operands are captured on a start pulse, then compared MSB-first one DIGIT per cycle.
- Stops at the first differing digit; applies the cascade input only when all digits are equal.
- Used for wide operands where a single-cycle WIDTH-bit comparator would break timing; result is presented with a done pulse.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; N = WIDTH/DIGIT digits.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iStart  input  1  start request; sampled only in IDLE.
- iData_a  input  WIDTH  operand A; captured when start is accepted.
- iData_b  input  WIDTH  operand B; captured when start is accepted.
- iData  input  3  cascade in, {gt,lt,eq}; captured when start is accepted.
- iSigned  input  1  signed compare select; port exists only with SEQ_CMP_SIGNED_EN.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse; result valid.
- oData  output  3  {gt,lt,eq}; exactly one bit set after the first completion.

Behaviour:
- Reset (async assert, sync release): state IDLE; oBusy=0, oDone=0, oData=3'b000; digit counter 0; operand registers 0.
- States IDLE, RUN, DONE.
  - IDLE: iStart=1 at an edge captures a, b and cascade; clears counter to N-1 (top digit); moves to RUN. oData keeps the previous result.
  - RUN: each edge compares digit[cnt] of A against B.
    - a>b -> oData<=100, go DONE.
    - a<b -> oData<=010, go DONE.
    - Equal and cnt>0 -> cnt-1, stay in RUN.
    - Equal and cnt==0 -> resolve cascade (100->gt, 010->lt, 001->eq, any other code->eq), go DONE.
  - DONE: oDone=1 for exactly one cycle; unconditionally returns to IDLE.
- Latency: oDone is high k cycles after the accepting edge, where k = digits examined (1..N). Minimum issue interval is k+1 cycles.
- iStart in RUN or DONE is ignored and not queued. Input changes after capture have no effect.
- oData is held from DONE until the next result is written. It is not cleared on a new start.
- Reset mid-RUN aborts the operation: no oDone; outputs return to reset values.
- N==1 is legal: always exactly one RUN cycle.

Optional Feature:
- Macro SEQ_CMP_SIGNED_EN.
- Defined: iSigned port exists. When iSigned=1 at capture, the MSB of both operands is inverted before storage, giving two's-complement ordering. The flag is latched with the operands.
- Undefined: no iSigned port; unsigned comparison only. Logic is otherwise identical.

Decomposition:
- Package seq_compare_pkg:
  - state encoding IDLE/RUN/DONE;
  - result constants RES_GT=3'b100, RES_LT=3'b010, RES_EQ=3'b001.
- Sub-module compare_digit: combinational DIGIT-bit compare producing gt/lt/eq; one instance, fed by muxed digit slices. The top-level block holds the FSM, counter and cascade resolution.

Test Plan:
- WIDTH=16, DIGIT=4, a=0x9000, b=0x1000, start -> oData=100; oDone 1 cycle after accept; oBusy high 1 cycle.
- a=0x1234, b=0x1235 -> oData=010; oDone 4 cycles after accept.
- a=b=0xABCD, iData=100 -> 100; repeat with iData=010 -> 010; with iData=011 -> 001 (default); each after 4 cycles.
- Start a=0x1234, b=0x1235; pulse iStart with new operands at cycles 2 and 4 (RUN, DONE) -> ignored; single oDone, oData=010.
- Assert iRst_n=0 in the 2nd RUN cycle of a=0x1111, b=0x1112 -> immediate oBusy=0, oData=000, no oDone; a new start afterwards completes normally.
- With SEQ_CMP_SIGNED_EN: a=0x8000, b=0x0001, iSigned=1 -> 010; iSigned=0 -> 100. Without the macro -> 100.
